// File: rtl/rr_arbiter_reg.sv
// Round-robin N:1 arbiter with valid/ready handshake and a registered output beat.
// Optional burst locking is compiled in with `define RR_ARB_LOCK_EN (adds the last port).
module rr_arbiter_reg #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   valid,
  input  logic [N-1:0][DATA_WIDTH-1:0]   data,
`ifdef RR_ARB_LOCK_EN
  input  logic [N-1:0]                   last,
`endif
  output logic [N-1:0]                   ready,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [ID_WIDTH-1:0]            id_o,
  input  logic                           ready_o
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N - 1);

  logic [ID_WIDTH-1:0]   ptr_reg;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic                  valid_o_reg;
  logic [DATA_WIDTH-1:0] data_o_reg;
  logic [ID_WIDTH-1:0]   id_o_reg;

  logic [N-1:0]          masked_req;
  logic [ID_WIDTH-1:0]   masked_idx;
  logic                  masked_any;
  logic [ID_WIDTH-1:0]   full_idx;
  logic [ID_WIDTH-1:0]   rr_idx;
  logic                  rr_any;

  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_any;
  logic                  accept;
  logic                  xfer;

  // Requests at or above the pointer win first; below-pointer requests wrap around.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign masked_req[gi] = valid[gi] & (ID_WIDTH'(gi) >= ptr_reg);
    end
  endgenerate

  always_comb begin
    masked_idx = '0;
    masked_any = 1'b0;
    full_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        masked_idx = ID_WIDTH'(i);
        masked_any = 1'b1;
      end
      if (valid[i]) begin
        full_idx = ID_WIDTH'(i);
      end
    end
  end

  assign rr_idx = masked_any ? masked_idx : full_idx;
  assign rr_any = |valid;

`ifdef RR_ARB_LOCK_EN
  logic                lock_reg;
  logic [ID_WIDTH-1:0] lock_id_reg;
  logic                beat_last;

  // A locked burst owner keeps the port even while idle.
  assign grant_idx = lock_reg ? lock_id_reg : rr_idx;
  assign grant_any = lock_reg ? valid[lock_id_reg] : rr_any;
  assign beat_last = last[grant_idx];
`else
  assign grant_idx = rr_idx;
  assign grant_any = rr_any;
`endif

  assign accept   = ~valid_o_reg | ready_o;
  assign xfer     = accept & grant_any;
  assign ptr_next = (grant_idx == LAST_ID) ? '0 : ID_WIDTH'(grant_idx + 1'b1);

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign ready[gi] = ~rst & xfer & (grant_idx == ID_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o_reg <= 1'b0;
      data_o_reg  <= '0;
      id_o_reg    <= '0;
      ptr_reg     <= '0;
`ifdef RR_ARB_LOCK_EN
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
`endif
    end else if (xfer) begin
      valid_o_reg <= 1'b1;
      data_o_reg  <= data[grant_idx];
      id_o_reg    <= grant_idx;
`ifdef RR_ARB_LOCK_EN
      // Pointer only moves when a burst ends.
      if (beat_last) begin
        lock_reg <= 1'b0;
        ptr_reg  <= ptr_next;
      end else begin
        lock_reg    <= 1'b1;
        lock_id_reg <= grant_idx;
      end
`else
      ptr_reg <= ptr_next;
`endif
    end else if (accept) begin
      valid_o_reg <= 1'b0;
    end
  end

  assign valid_o = valid_o_reg;
  assign data_o  = data_o_reg;
  assign id_o    = id_o_reg;

endmodule

// File: tb/tb_rr_arbiter_reg.sv
// Bench for rr_arbiter_reg: directed vector table, corner sequences and a random run
// checked against a modular-arithmetic round-robin model.
module tb_rr_arbiter_reg;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] valid;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0] last_in;
  logic [N-1:0] ready;
  logic valid_o;
  logic [DW-1:0] data_o;
  logic [IW-1:0] id_o;
  logic ready_o;

  always #5 clk = ~clk;

  rr_arbiter_reg #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .data(data),
`ifdef RR_ARB_LOCK_EN
    .last(last_in),
`endif
    .ready(ready),
    .valid_o(valid_o),
    .data_o(data_o),
    .id_o(id_o),
    .ready_o(ready_o)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int            m_ptr;
  bit            m_vo;
  logic [DW-1:0] m_data;
  int            m_id;
  bit            m_lock;
  int            m_lid;
  int            last_g;
  logic [N-1:0]  ready_seen;

  typedef struct {
    logic [N-1:0] v;
    logic         ro;
    logic [N-1:0] er;
    logic         evo;
    int           eid;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 2) ? 32'hDEADBEEF : DW'(32'h1000_0000 + i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_vo = 1'b0; m_data = '0; m_id = 0; m_lock = 1'b0; m_lid = 0;
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic apply(input logic [N-1:0] v, input logic ro);
    bit acc;
    int g;
    logic [N-1:0] er;
    valid = v; ready_o = ro;
    #1;
    acc = !m_vo || ro;
    g = -1;
    if (m_lock) begin
      if (v[m_lid]) g = m_lid;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = '0;
    if (acc && g >= 0) er[g] = 1'b1;
    ready_seen = ready;
    chk("ready", ready, er);
    last_g = (acc && g >= 0) ? g : -1;
    @(posedge clk);
    if (acc) begin
      if (g >= 0) begin
        m_vo = 1'b1; m_data = data[g]; m_id = g;
        if (LOCK_EN && !last_in[g]) begin
          m_lock = 1'b1; m_lid = g;
        end else begin
          m_lock = 1'b0; m_ptr = (g + 1) % N;
        end
      end else begin
        m_vo = 1'b0;
      end
    end
    #1;
    chk("valid_o", valid_o, m_vo);
    chk("id_o", id_o, m_id);
    chk("data_o", data_o, m_data);
    @(negedge clk);
  endtask

  initial begin
    int prev_g;
    // rotation, wrap-around, backpressure, idle
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
    tbl[9]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0};
    tbl[10] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 1};
    tbl[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
    tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
    tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
    tbl[14] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
    tbl[15] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1};

    rst = 1'b1; valid = 4'b1111; ready_o = 1'b0; last_in = '1;
    for (int i = 0; i < N; i++) data[i] = pat(i);
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("rst_ready", ready, 4'b0000);
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_id_o", id_o, 2'd0);
    chk("rst_data_o", data_o, 32'd0);
    valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].v, tbl[i].ro);
      $display("[TB] vec %0d valid=%b ready_o=%b ready=%b valid_o=%b id_o=%0d", i,
               tbl[i].v, tbl[i].ro, ready_seen, valid_o, id_o);
      chk("tbl_ready", ready_seen, tbl[i].er);
      chk("tbl_valid_o", valid_o, tbl[i].evo);
      chk("tbl_id_o", id_o, tbl[i].eid);
      if (tbl[i].evo) chk("tbl_data_o", data_o, pat(tbl[i].eid));
    end

    // asynchronous reset in the middle of a cycle with a beat pending
    apply(4'b0100, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_o", valid_o, 1'b0);
    chk("arst_id_o", id_o, 2'd0);
    chk("arst_data_o", data_o, 32'd0);
    chk("arst_ready", ready, 4'b0000);
    $display("[TB] async reset valid_o=%b id_o=%0d", valid_o, id_o);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      apply(4'b0000, 1'b1);
      chk("idle_valid_o", valid_o, 1'b0);
      chk("idle_ready", ready_seen, 4'b0000);
    end

    // requester 0 held, requester 3 pulsing: 0 never wins twice while 3 waits
    prev_g = -1;
    for (int c = 0; c < 20; c++) begin
      logic [N-1:0] v;
      v = {(c % 2 == 0), 2'b00, 1'b1};
      apply(v, 1'b1);
      $display("[TB] starve c=%0d valid=%b grant=%0d", c, v, last_g);
      if (prev_g == 0 && v[3]) chk("starve", last_g, 3);
      prev_g = last_g;
    end

`ifdef RR_ARB_LOCK_EN
    // burst from requester 1 while everyone requests
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    @(negedge clk);
    last_in = '1;
    apply(4'b1111, 1'b1);
    chk("lock_pre_id", id_o, 2'd0);
    last_in = 4'b1101;
    apply(4'b1111, 1'b1);
    chk("lock_b0_id", id_o, 2'd1);
    apply(4'b1111, 1'b1);
    chk("lock_b1_id", id_o, 2'd1);
    apply(4'b1101, 1'b1);
    chk("lock_idle_ready", ready_seen, 4'b0000);
    last_in = '1;
    apply(4'b1111, 1'b1);
    chk("lock_b2_id", id_o, 2'd1);
    apply(4'b1111, 1'b1);
    chk("lock_next_id", id_o, 2'd2);
    $display("[TB] lock burst done id_o=%0d", id_o);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] v;
      logic ro;
      for (int k = 0; k < N; k++) data[k] = $urandom;
      v  = N'($urandom_range(0, 15));
      ro = ($urandom_range(0, 3) != 0);
      if (LOCK_EN) last_in = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
      apply(v, ro);
      $display("[TB] rnd %0d valid=%b ready_o=%b ready=%b valid_o=%b id_o=%0d data_o=%h",
               i, v, ro, ready_seen, valid_o, id_o, data_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
